key_led_sched: RTL and testbench
================================

Name: key_led_sched

Overview:
Mode controller for the two-key / two-LED board datapath. Synchronises and debounces both keys, converts presses into single-cycle events, and steps a 4-state LED mode FSM. A shared timebase counter (CNT_MAX) drives the blink phase. Sits between the raw board keys and the LED pins, replacing direct key-to-LED wiring.

Parameters:
CNT_MAX, 25'd24_999_999, blink half-period minus 1 in sys_clk cycles (0.5 s at 50 MHz); 25-bit.
DEB_MAX, 20'd999_999, debounce window minus 1 in sys_clk cycles (20 ms at 50 MHz); 20-bit.

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst  input  1  synchronous reset, active-high
key      input  2  raw board keys, active-low (0 = pressed), asynchronous to sys_clk
led      output 2  LED drive, active-high, registered
mode     output 2  current FSM state, registered (debug/status)

Behaviour:
- Reset (sys_rst=1 at a clock edge): led=2'b00, mode=2'd0, sync regs=2'b11, debounced state=2'b11, debounce counters=0, timebase cnt=0, phase=0. Reset wins over every other event, including mid-debounce and mid-blink.
- Sync: 2-FF synchroniser per key bit; the debouncer sees key 2 cycles late.
- Debounce, per bit: if sync != stable, the counter increments; if sync == stable, the counter clears to 0. When the counter == DEB_MAX and sync still differs, stable <= sync and the counter clears. So stable changes only after DEB_MAX+1 consecutive differing cycles. A glitch shorter than that has no effect.
- Press event: press[i] is a 1-cycle pulse when stable[i] goes 1->0. Release (0->1) produces no event. Holding a key produces exactly one event.
- FSM states: OFF=0, ALT=1, SYNC=2, ON=3.
  - press[0]: mode <= mode+1, wrapping 3->0.
  - press[1]: mode <= OFF.
  - Both in the same cycle: press[1] wins (OFF).
  - Otherwise hold.
- Mode register updates on the cycle after the press pulse.
- Timebase: cnt counts 0..CNT_MAX. At cnt == CNT_MAX, cnt <= 0 and phase toggles.
  - Any mode change clears cnt to 0 and phase to 0 in the same cycle mode updates.
  - cnt runs in all states; phase is ignored in OFF and ON.
- LED map, registered one cycle after mode/phase:
  - OFF -> 00
  - ALT -> phase ? 10 : 01
  - SYNC -> phase ? 11 : 00
  - ON -> 11
- Total latency from raw key edge to led change: 2 sync + (DEB_MAX+1) debounce + 1 press + 1 mode + 1 led = DEB_MAX+6 cycles.
- Blink period = 2*(CNT_MAX+1) cycles; the first half after entering ALT/SYNC is phase 0.

Optional Feature:
Macro KEY_LED_REVERSE_EN.
- Defined: press[1] steps mode backwards (mode-1, wrapping 0->3). Simultaneous press[0] and press[1] forces OFF.
- Undefined: press[1] forces OFF as described above.
- Reset values and the LED map are unchanged either way.

Test Plan:
1. Bench overrides CNT_MAX=25, DEB_MAX=4. Hold sys_rst=1 for 2 cycles with key=00 -> led=00, mode=0. Release reset with key=11 -> led stays 00.
2. key[0]=0 held 20 cycles from cycle T -> mode=1 at T+8 and stays 1 (one event only). led=01 at T+9, toggles to 10 at T+9+26, period 52 cycles.
3. key[0] low for 3 cycles then high (glitch) -> mode, led unchanged.
4. Four clean key[0] presses from OFF -> mode sequence 1,2,3,0. In SYNC, led alternates 00/11 every 26 cycles. In ON, led=11 constant.
5. In ALT, press key[1]:
   - without KEY_LED_REVERSE_EN -> mode=0, led=00.
   - with the macro -> mode=0, then a second press -> mode=3, led=11.
   - Both keys falling on the same cycle -> OFF in both builds.
6. Assert sys_rst for 1 cycle mid-debounce of key[0] while in SYNC -> next cycle led=00, mode=0, cnt=0. The held key then needs a full DEB_MAX+1 window again before mode=1.

Source files
------------

// File: rtl/key_led_sched.sv
// key_led_sched
//   LED mode controller for the two-key / two-LED board. The raw keys are
//   synchronised and debounced. A 1->0 transition of a debounced key makes a
//   single-cycle press event. Press events step a 4-state mode FSM, and a
//   shared timebase sets the blink phase for the blinking modes.
//
//   Modes: OFF=0 (00), ALT=1 (01/10 blink), SYNC=2 (00/11 blink), ON=3 (11).
//   key[0] steps the mode forward. key[1] forces OFF. If both keys press in
//   the same cycle, key[1] wins.
//
//   Optional build macro KEY_LED_REVERSE_EN:
//     When defined, key[1] steps the mode backwards instead, and both keys
//     pressed together force OFF.
//
// Parameters:
//   CNT_MAX  blink half-period minus 1, in sys_clk cycles
//   DEB_MAX  debounce window minus 1, in sys_clk cycles
//
// Ports:
//   sys_clk  in   system clock, rising edge
//   sys_rst  in   synchronous reset, active-high
//   key[1:0] in   raw keys, active-low, asynchronous to sys_clk
//   led[1:0] out  LED drive, active-high, registered
//   mode     out  current FSM state, registered

module key_led_sched #(
    parameter logic [24:0] CNT_MAX = 25'd24_999_999,
    parameter logic [19:0] DEB_MAX = 20'd999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] key,
    output logic [1:0] led,
    output logic [1:0] mode
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_ALT  = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;
    localparam logic [1:0] ST_ON   = 2'd3;

    logic [1:0]  key_s1, key_s2;   // 2-FF synchroniser
    logic [1:0]  stable;           // debounced key level
    logic [1:0]  stable_d;         // debounced level, one cycle older
    logic [1:0]  press;            // registered press pulse
    logic [19:0] deb_cnt [2];
    logic [24:0] cnt;
    logic        phase;
    logic [1:0]  mode_nxt;
    logic        mode_chg;
    logic [1:0]  led_nxt;

    // NOTE: sequential state is written with <= only, so every register
    // samples its inputs as they were before the clock edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
        end
    end

    // Per-bit debouncer. The level is accepted only after DEB_MAX+1
    // consecutive cycles that differ from the current stable value.
    // NOTE: the debounce counters are a two-entry array of plain flops, not a
    // memory, so they are cleared in the reset branch along with everything else.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stable <= 2'b11;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (key_s2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    stable[i]  <= key_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 20'd1;
                end
            end
        end
    end

    // Press = falling edge of the debounced level. A release produces no event.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stable_d <= 2'b11;
            press    <= 2'b00;
        end else begin
            stable_d <= stable;
            press    <= stable_d & ~stable;
        end
    end

    // NOTE: the default assignment at the top of this always_comb block
    // gives mode_nxt a value on every path, so no latch is inferred.
    always_comb begin
        mode_nxt = mode;
`ifdef KEY_LED_REVERSE_EN
        if (press == 2'b11)
            mode_nxt = ST_OFF;
        else if (press[0])
            mode_nxt = mode + 2'd1;
        else if (press[1])
            mode_nxt = mode - 2'd1;
`else
        if (press[1])
            mode_nxt = ST_OFF;
        else if (press[0])
            mode_nxt = mode + 2'd1;
`endif
    end

    assign mode_chg = (mode_nxt != mode);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) mode <= ST_OFF;
        else         mode <= mode_nxt;
    end

    // Timebase. A mode change restarts it, so a blinking mode always begins
    // with a full phase-0 half period.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || mode_chg) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 25'd1;
        end
    end

    always_comb begin
        led_nxt = 2'b00;
        case (mode)
            ST_OFF:  led_nxt = 2'b00;
            ST_ALT:  led_nxt = phase ? 2'b10 : 2'b01;
            ST_SYNC: led_nxt = phase ? 2'b11 : 2'b00;
            ST_ON:   led_nxt = 2'b11;
            default: led_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) led <= 2'b00;
        else         led <= led_nxt;
    end

endmodule

// File: tb/tb_key_led_sched.sv
// Directed testbench for key_led_sched with CNT_MAX=25 and DEB_MAX=4.
// Inputs are driven 1 ns after a rising edge, and outputs are sampled at the
// same point. If a key is driven after edge E, the first edge that samples it
// is T = E+1. The mode then changes at edge T+8 and the LED changes at T+9.

module tb_key_led_sched;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [1:0] key     = 2'b00;
    logic [1:0] led;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    key_led_sched #(
        .CNT_MAX(25'd25),
        .DEB_MAX(20'd4)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .key    (key),
        .led    (led),
        .mode   (mode)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Clean press of the keys set in k: hold for 10 cycles, then release for
    // 10 cycles. The task returns at T+19, after mode and LED have updated.
    task automatic press_key(input logic [1:0] k);
        key = ~k;
        cyc(10);
        key = 2'b11;
        cyc(10);
    endtask

    // Call at T+19 after entering a blinking mode.
    // The phase flips at T+35 and again at T+61.
    task automatic blink_check(input string tag, input logic [1:0] e0, input logic [1:0] e1);
        cyc(15); check({tag, "_ph0_end"},  led, e0);
        cyc(1);  check({tag, "_ph1_start"}, led, e1);
        cyc(25); check({tag, "_ph1_end"},  led, e1);
        cyc(1);  check({tag, "_ph0_again"}, led, e0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then release with the keys idle.
        sys_rst = 1'b1;
        key     = 2'b00;
        cyc(2);
        check("rst_led",  led,  2'b00);
        check("rst_mode", mode, 2'd0);
        sys_rst = 1'b0;
        key     = 2'b11;
        cyc(15);
        check("idle_led",  led,  2'b00);
        check("idle_mode", mode, 2'd0);

        // key[0] is held for 20 cycles: exact latency, a single event, then ALT blink.
        key = 2'b10;
        cyc(8);  check("lat_mode_before", mode, 2'd0);
        cyc(1);  check("lat_mode_at",     mode, 2'd1);
                 check("lat_led_before",  led,  2'b00);
        cyc(1);  check("lat_led_at",      led,  2'b01);
        cyc(10); check("hold_one_event",  mode, 2'd1);
        key = 2'b11;
        blink_check("alt", 2'b01, 2'b10);

        // Glitches of 3 cycles and of DEB_MAX (4) cycles are both ignored.
        key = 2'b10; cyc(3); key = 2'b11; cyc(12);
        check("glitch3_mode", mode, 2'd1);
        key = 2'b10; cyc(4); key = 2'b11; cyc(12);
        check("glitch4_mode", mode, 2'd1);

        // key[1] pressed in ALT gives OFF in both builds.
        press_key(2'b10);
        check("k1_alt_mode", mode, 2'd0);
        check("k1_alt_led",  led,  2'b00);
`ifdef KEY_LED_REVERSE_EN
        press_key(2'b10);
        check("rev_wrap_mode", mode, 2'd3);
        check("rev_wrap_led",  led,  2'b11);
        press_key(2'b01);
        check("rev_fwd_wrap_mode", mode, 2'd0);
`else
        press_key(2'b10);
        check("k1_off_hold_mode", mode, 2'd0);
        check("k1_off_hold_led",  led,  2'b00);
`endif

        // Four key[0] presses starting from OFF step through 1, 2, 3, 0.
        press_key(2'b01);
        check("seq_mode1", mode, 2'd1);
        blink_check("seq_alt", 2'b01, 2'b10);
        press_key(2'b01);
        check("seq_mode2", mode, 2'd2);
        blink_check("sync", 2'b00, 2'b11);
        press_key(2'b01);
        check("seq_mode3", mode, 2'd3);
        check("on_led",    led,  2'b11);
        cyc(40);
        check("on_led_steady", led, 2'b11);
        press_key(2'b01);
        check("seq_mode0", mode, 2'd0);
        check("seq_led0",  led,  2'b00);

        // Both keys pressed together in SYNC give OFF in both builds.
        press_key(2'b01);
        press_key(2'b01);
        check("both_pre_mode", mode, 2'd2);
        press_key(2'b11);
        check("both_mode", mode, 2'd0);
        check("both_led",  led,  2'b00);

        // Reset mid-debounce while in SYNC. The held key then needs a full
        // new window before it takes effect.
        press_key(2'b01);
        press_key(2'b01);
        check("mid_pre_mode", mode, 2'd2);
        key = 2'b10;
        cyc(4);
        sys_rst = 1'b1;
        cyc(1);
        sys_rst = 1'b0;
        check("mid_rst_led",  led,  2'b00);
        check("mid_rst_mode", mode, 2'd0);
        cyc(8); check("mid_rewin_before", mode, 2'd0);
        cyc(1); check("mid_rewin_at",     mode, 2'd1);
        cyc(1); check("mid_rewin_led",    led,  2'b01);
        key = 2'b11;
        cyc(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
